// File: rtl/can_rx_msg_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : can_rx_msg_fifo_pkg
//  Description : Shared types and helpers for the CAN receive message FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package can_rx_msg_fifo_pkg;

    localparam int c_MAX_BYTES = 8;

    typedef struct packed {
        logic [28:0]     id;
        logic            ide;
        logic            rtr;
        logic [3:0]      dlc;
        logic [7:0][7:0] data;
        logic [3:0]      hit;
    } can_frame_t;

    // Hit code used when no filter is enabled: one past the last filter index.
    function automatic logic [3:0] can_accept_all(input int num_filters);
        return 4'(num_filters);
    endfunction

    // Zero every byte beyond the effective payload length (RTR carries none).
    function automatic logic [7:0][7:0] can_sanitise_data(input logic [7:0][7:0] data,
                                                          input logic [3:0]      dlc,
                                                          input logic            rtr);
        logic [3:0]      len;
        logic [7:0][7:0] res;
        len = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
        for (int i = 0; i < c_MAX_BYTES; i++) begin
            res[i] = (4'(i) < len) ? data[i] : 8'h00;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_rx_msg_fifo_acc_filter.sv
`default_nettype none
// ============================================================================
//  Module      : can_acc_filter
//  Description : Combinational bank of ID/mask acceptance filters.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_acc_filter
    import can_rx_msg_fifo_pkg::*;
#(
    parameter int NUM_FILTERS = 2
) (
    input  logic [28:0]                  id,
    input  logic                         ide,
    input  logic [NUM_FILTERS-1:0]       flt_en,
    input  logic [NUM_FILTERS-1:0]       flt_ide,
    input  logic [NUM_FILTERS-1:0][28:0] flt_id,
    input  logic [NUM_FILTERS-1:0][28:0] flt_mask,
    output logic                         accept,
    output logic [3:0]                   hit_idx
);

    logic [NUM_FILTERS-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_flt
            assign w_hit[gi] = flt_en[gi] && (flt_ide[gi] == ide) &&
                               (((id ^ flt_id[gi]) & flt_mask[gi]) == 29'd0);
        end
    endgenerate

    // Scan downwards so the lowest hitting filter wins.
    always_comb begin
        accept  = 1'b0;
        hit_idx = can_accept_all(NUM_FILTERS);
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                accept  = 1'b1;
                hit_idx = 4'(i);
            end
        end
        if (flt_en == '0) begin
            accept = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_rx_msg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : can_rx_msg_fifo
//  Description : Filtered, overrun-aware show-ahead FIFO of received CAN frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_rx_msg_fifo
    import can_rx_msg_fifo_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int NUM_FILTERS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_done_flag,
    input  logic                          rx_ide,
    input  logic [10:0]                   rx_id_std,
    input  logic [17:0]                   rx_id_ext,
    input  logic                          rx_rtr,
    input  logic [3:0]                    rx_dlc,
    input  logic [7:0][7:0]               rx_data_array,
    input  logic [NUM_FILTERS-1:0]        flt_en,
    input  logic [NUM_FILTERS-1:0]        flt_ide,
    input  logic [NUM_FILTERS-1:0][28:0]  flt_id,
    input  logic [NUM_FILTERS-1:0][28:0]  flt_mask,
    input  logic                          flush,
    input  logic                          rd_en,
    output logic                          out_valid,
    output can_frame_t                    out_frame,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overrun,
    output logic [7:0]                    overrun_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [28:0]     w_cmp_id;
    logic            w_accept;
    logic [3:0]      w_hit_idx;

    logic            r_s1_valid;
    logic            r_s1_accept;
    can_frame_t      r_s1_frame;

    can_frame_t      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overrun;
    logic [7:0]      r_ovr_cnt;

    logic            w_full;
    logic            w_pop;
    logic            w_accepted;
    logic            w_commit;
    logic            w_drop;

    assign w_cmp_id = rx_ide ? {rx_id_std, rx_id_ext} : {rx_id_std, 18'd0};

    can_acc_filter #(
        .NUM_FILTERS (NUM_FILTERS)
    ) u_filter (
        .id       (w_cmp_id),
        .ide      (rx_ide),
        .flt_en   (flt_en),
        .flt_ide  (flt_ide),
        .flt_id   (flt_id),
        .flt_mask (flt_mask),
        .accept   (w_accept),
        .hit_idx  (w_hit_idx)
    );

    // Capture stage: filter verdict and sanitised payload registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_accept <= 1'b0;
            r_s1_frame  <= '0;
        end else begin
            r_s1_valid <= rx_done_flag && !flush;
            if (rx_done_flag) begin
                r_s1_accept     <= w_accept;
                r_s1_frame.id   <= w_cmp_id;
                r_s1_frame.ide  <= rx_ide;
                r_s1_frame.rtr  <= rx_rtr;
                r_s1_frame.dlc  <= rx_dlc;
                r_s1_frame.data <= can_sanitise_data(rx_data_array, rx_dlc, rx_rtr);
                r_s1_frame.hit  <= w_hit_idx;
            end
        end
    end

    // A pop in the same cycle frees the slot a full FIFO needs for the commit.
    assign w_full     = (r_count == c_CW'(DEPTH));
    assign w_pop      = rd_en && (r_count != '0) && !flush;
    assign w_accepted = r_s1_valid && r_s1_accept && !flush;
    assign w_commit   = w_accepted && (!w_full || w_pop);
    assign w_drop     = w_accepted && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr] <= r_s1_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= 8'd0;
        end else begin
            r_overrun <= w_drop;
            if (w_drop && (r_ovr_cnt != 8'hFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_frame   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count       = r_count;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovr_cnt;

endmodule
`default_nettype wire
